// File: rtl/serializer_pkg.sv
// Shared types and constants for the word-to-bit serializer.
package serializer_pkg;

  // Serializer control states: waiting for a word, shifting bits out, inter-word gap.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_t;

  // Number of words the input buffer can hold.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO. Pushing while full and popping while empty are ignored.
module sync_fifo2
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; its contents are meaningless unless count says so, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_bit_serializer.sv
// Buffers parallel words and emits them MSB-first, one bit per clock, framed by first/last.
module word_bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_bit,
  output logic             m_valid,
  output logic             m_first,
  output logic             m_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW       = $clog2(WIDTH);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  ser_state_t       state, next_state;
  logic [WIDTH-1:0] shreg, next_shreg;
  logic [BW-1:0]    bit_cnt, next_bit_cnt;
  logic [GW-1:0]    gap_cnt, next_gap_cnt;
  logic [CNT_W-1:0] next_words;
  logic             next_m_bit, next_m_valid, next_m_first, next_m_last;
  logic             next_busy;
  logic             load;

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_data;
  logic [1:0]       fifo_count;
  logic [1:0]       next_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Ready depends only on the registered occupancy, so a pop in the same cycle never frees a slot early.
  assign s_ready    = !fifo_full && !rst;
  assign fifo_push  = s_valid && s_ready;
  assign next_count = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};

  sync_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (s_data),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state logic; the outputs describe the bit that will be on the wire next cycle.
  always_comb begin
    next_state   = state;
    next_shreg   = shreg;
    next_bit_cnt = bit_cnt;
    next_gap_cnt = gap_cnt;
    next_words   = words_sent;
    next_m_bit   = 1'b0;
    next_m_valid = 1'b0;
    next_m_first = 1'b0;
    next_m_last  = 1'b0;
    fifo_pop     = 1'b0;
    load         = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      S_SHIFT: begin
        if (bit_cnt == '0) begin
          next_words = words_sent + CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            next_state   = S_GAP;
            next_gap_cnt = GW'(GAP_INIT);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end else begin
          next_shreg   = shreg << 1;
          next_bit_cnt = bit_cnt - BW'(1);
          next_m_valid = 1'b1;
          next_m_bit   = shreg[WIDTH-2];
          next_m_last  = (bit_cnt == BW'(1));
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          if (!fifo_empty) load = 1'b1;
          else             next_state = S_IDLE;
        end else begin
          next_gap_cnt = gap_cnt - GW'(1);
        end
      end
      default: next_state = S_IDLE;
    endcase

    if (load) begin
      fifo_pop     = 1'b1;
      next_state   = S_SHIFT;
      next_shreg   = fifo_data;
      next_bit_cnt = BW'(WIDTH - 1);
      next_m_valid = 1'b1;
      next_m_bit   = fifo_data[WIDTH-1];
      next_m_first = 1'b1;
    end

    next_busy = (next_state != S_IDLE) || (next_count != 2'd0);
  end

  // State, datapath and registered outputs; reset discards any partially emitted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      words_sent <= '0;
      m_bit      <= 1'b0;
      m_valid    <= 1'b0;
      m_first    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      shreg      <= next_shreg;
      bit_cnt    <= next_bit_cnt;
      gap_cnt    <= next_gap_cnt;
      words_sent <= next_words;
      m_bit      <= next_m_bit;
      m_valid    <= next_m_valid;
      m_first    <= next_m_first;
      m_last     <= next_m_last;
      busy       <= next_busy;
    end
  end

endmodule

// File: tb/tb_word_bit_serializer.sv
// Directed bench: instance a uses a 1-cycle gap, instance b is back-to-back with a 4-bit counter.
module tb_word_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;

  logic       s_valid_a = 1'b0;
  logic [7:0] s_data_a  = 8'h00;
  logic       s_ready_a, m_bit_a, m_valid_a, m_first_a, m_last_a, busy_a;
  logic [15:0] words_a;

  logic       s_valid_b = 1'b0;
  logic [7:0] s_data_b  = 8'h00;
  logic       s_ready_b, m_bit_b, m_valid_b, m_first_b, m_last_b, busy_b;
  logic [3:0] words_b;

  int n_checks = 0;
  int n_errors = 0;
  int ready_low_seen = 0;
  int zero_viol = 0;

  logic qa_bit[$], qa_first[$], qa_last[$];
  int   qa_cyc[$];
  logic qb_bit[$], qb_first[$], qb_last[$];
  int   qb_cyc[$];

  word_bit_serializer #(.WIDTH(8), .GAP_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .m_bit(m_bit_a), .m_valid(m_valid_a), .m_first(m_first_a), .m_last(m_last_a),
    .busy(busy_a), .words_sent(words_a)
  );

  word_bit_serializer #(.WIDTH(8), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_bit(m_bit_b), .m_valid(m_valid_b), .m_first(m_first_b), .m_last(m_last_b),
    .busy(busy_b), .words_sent(words_b)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted bit of instance a shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (m_valid_a) begin
      qa_bit.push_back(m_bit_a); qa_first.push_back(m_first_a);
      qa_last.push_back(m_last_a); qa_cyc.push_back(cyc);
    end else if (m_bit_a || m_first_a || m_last_a) zero_viol++;
  end

  // Record every emitted bit of instance b shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (m_valid_b) begin
      qb_bit.push_back(m_bit_b); qb_first.push_back(m_first_b);
      qb_last.push_back(m_last_b); qb_cyc.push_back(cyc);
    end else if (m_bit_b || m_first_b || m_last_b) zero_viol++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word_at(input int sel, input int idx);
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++)
      w = {w[6:0], (sel == 0) ? qa_bit[idx+i] : qb_bit[idx+i]};
    return w;
  endfunction

  function automatic int count_flags(input int sel, input int last);
    int n = 0;
    int sz = (sel == 0) ? qa_bit.size() : qb_bit.size();
    for (int i = 0; i < sz; i++) begin
      if (sel == 0) n += int'(last ? qa_last[i] : qa_first[i]);
      else          n += int'(last ? qb_last[i] : qb_first[i]);
    end
    return n;
  endfunction

  // Offer one word to the selected instance; returns on the falling edge after it was accepted.
  task automatic applyStimulus(input int sel, input logic [7:0] w);
    logic acc;
    int   guard = 0;
    if (sel == 0) begin s_valid_a = 1'b1; s_data_a = w; end
    else          begin s_valid_b = 1'b1; s_data_b = w; end
    forever begin
      acc = (sel == 0) ? s_ready_a : s_ready_b;
      if (!acc) ready_low_seen++;
      @(negedge clk);
      if (acc) break;
      guard++;
      if (guard > 100) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int sel);
    int   n = 0;
    logic idle = 1'b0;
    if (sel == 0) s_valid_a = 1'b0; else s_valid_b = 1'b0;
    while (n < 300 && !idle) begin
      @(negedge clk);
      idle = (sel == 0) ? (!busy_a && !m_valid_a) : (!busy_b && !m_valid_b);
      n++;
    end
    checkOutput("idle_reached", {31'd0, idle}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ready_in_rst", {31'd0, s_ready_a}, 32'd0);
    rst = 1'b0;
    qa_bit.delete(); qa_first.delete(); qa_last.delete(); qa_cyc.delete();
    qb_bit.delete(); qb_first.delete(); qb_last.delete(); qb_cyc.delete();
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, s_ready_a}, 32'd1);
  endtask

  initial begin
    int push_cyc;
    int rem;
    logic [7:0] t4 [4];
    t4[0] = 8'h81; t4[1] = 8'hFF; t4[2] = 8'h00; t4[3] = 8'h3C;

    // Reset state
    do_reset();
    checkOutput("rst_m_valid", {31'd0, m_valid_a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_words", {16'd0, words_a}, 32'd0);

    // Single word 0x0A: latency, framing and bit order
    push_cyc = cyc;
    applyStimulus(0, 8'h0A);
    wait_idle(0);
    checkOutput("t1_len", qa_bit.size(), 32'd8);
    if (qa_bit.size() >= 8) begin
      checkOutput("t1_word", {24'd0, word_at(0, 0)}, 32'h0A);
      checkOutput("t1_first0", {31'd0, qa_first[0]}, 32'd1);
      checkOutput("t1_last7", {31'd0, qa_last[7]}, 32'd1);
      checkOutput("t1_msb_lat", qa_cyc[0] - push_cyc, 32'd2);
      checkOutput("t1_lsb_lat", qa_cyc[7] - push_cyc, 32'd9);
      rem = 0;
      for (int i = 0; i < 8; i++) rem = (rem * 2 + int'(qa_bit[i])) % 5;
      checkOutput("t1_div5_rem", rem, 32'd0);
    end
    checkOutput("t1_nfirst", count_flags(0, 0), 32'd1);
    checkOutput("t1_nlast", count_flags(0, 1), 32'd1);
    checkOutput("t1_words", {16'd0, words_a}, 32'd1);

    // Two words back-to-back with one idle cycle between them
    do_reset();
    applyStimulus(0, 8'h0A);
    applyStimulus(0, 8'h0F);
    wait_idle(0);
    checkOutput("t2_len", qa_bit.size(), 32'd16);
    if (qa_bit.size() >= 16) begin
      checkOutput("t2_word0", {24'd0, word_at(0, 0)}, 32'h0A);
      checkOutput("t2_word1", {24'd0, word_at(0, 8)}, 32'h0F);
      checkOutput("t2_gap", qa_cyc[8] - qa_cyc[7], 32'd2);
      checkOutput("t2_first8", {31'd0, qa_first[8]}, 32'd1);
    end
    checkOutput("t2_words", {16'd0, words_a}, 32'd2);

    // Back-pressure: four words offered continuously
    do_reset();
    ready_low_seen = 0;
    for (int i = 0; i < 4; i++) applyStimulus(0, t4[i]);
    wait_idle(0);
    checkOutput("t4_ready_dropped", {31'd0, ready_low_seen > 0}, 32'd1);
    checkOutput("t4_len", qa_bit.size(), 32'd32);
    if (qa_bit.size() >= 32)
      for (int i = 0; i < 4; i++) checkOutput("t4_word", {24'd0, word_at(0, 8 * i)}, {24'd0, t4[i]});
    checkOutput("t4_nfirst", count_flags(0, 0), 32'd4);
    checkOutput("t4_words", {16'd0, words_a}, 32'd4);

    // Reset on the 4th bit of 0x5A, then a clean word
    do_reset();
    applyStimulus(0, 8'h5A);
    s_valid_a = 1'b0;
    for (int n = 0; n < 50 && qa_bit.size() < 4; n++) @(negedge clk);
    checkOutput("t5_reached_bit4", qa_bit.size(), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_m_valid", {31'd0, m_valid_a}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("t5_words", {16'd0, words_a}, 32'd0);
    checkOutput("t5_ready_in_rst", {31'd0, s_ready_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_no_last", count_flags(0, 1), 32'd0);
    applyStimulus(0, 8'hC3);
    wait_idle(0);
    checkOutput("t5_len", qa_bit.size(), 32'd12);
    if (qa_bit.size() >= 12) begin
      checkOutput("t5_partial", {28'd0, qa_bit[0], qa_bit[1], qa_bit[2], qa_bit[3]}, 32'h5);
      checkOutput("t5_first4", {31'd0, qa_first[4]}, 32'd1);
      checkOutput("t5_word", {24'd0, word_at(0, 4)}, 32'hC3);
    end
    checkOutput("t5_words_after", {16'd0, words_a}, 32'd1);

    // No gap: three words give 24 contiguous valid cycles
    do_reset();
    applyStimulus(1, 8'h12);
    applyStimulus(1, 8'h34);
    applyStimulus(1, 8'h56);
    wait_idle(1);
    checkOutput("t3_len", qb_bit.size(), 32'd24);
    if (qb_bit.size() >= 24) begin
      checkOutput("t3_contig", qb_cyc[23] - qb_cyc[0], 32'd23);
      checkOutput("t3_first_pos", {30'd0, qb_first[8], qb_first[16]}, 32'h3);
      checkOutput("t3_word2", {24'd0, word_at(1, 16)}, 32'h56);
    end
    checkOutput("t3_nfirst", count_flags(1, 0), 32'd3);
    checkOutput("t3_words", {28'd0, words_b}, 32'd3);

    // Counter wrap on a 4-bit words_sent
    do_reset();
    for (int i = 0; i < 15; i++) applyStimulus(1, 8'(i * 17 + 1));
    wait_idle(1);
    checkOutput("t6_words15", {28'd0, words_b}, 32'd15);
    applyStimulus(1, 8'hA5);
    wait_idle(1);
    checkOutput("t6_words16", {28'd0, words_b}, 32'd0);
    applyStimulus(1, 8'h5A);
    wait_idle(1);
    checkOutput("t6_words17", {28'd0, words_b}, 32'd1);
    checkOutput("t6_len", qb_bit.size(), 32'd136);

    checkOutput("idle_outputs_zero", zero_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
